// File: rtl/adc_spi_responder.sv
// Target-side model of an ADC128S022-style 8-channel serial ADC.
// Oversamples the SPI pins on clk, decodes the channel address and shifts out the selected sample.
module adc_spi_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adc_cs_n,
  input  logic                       adc_sck,
  input  logic                       adc_din,
  output logic                       adc_dout,
  input  logic [N_CH*DATA_W-1:0]     chan_data,
  output logic [$clog2(N_CH)-1:0]    cur_channel,
  output logic                       frame_done,
  output logic                       frame_abort
);

  localparam int unsigned ADDR_W  = $clog2(N_CH);
  localparam int unsigned FRAME_W = DATA_W + 4;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(2);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(1 + ADDR_W);

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, din_sync;
  logic                   cs_prev, sck_prev;
  logic                   cs_s, sck_s, din_s;
  logic                   cs_fall_c, cs_rise_c, sck_rise_c, sck_fall_c;

  logic [0:0]         state, state_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]   rcnt, rcnt_nxt;
  logic [CNT_W-1:0]   fcnt, fcnt_nxt;
  logic [ADDR_W-1:0]  addr_sh, addr_sh_nxt;
  logic [ADDR_W-1:0]  cur_channel_nxt;
  logic               adc_dout_nxt, frame_done_nxt, frame_abort_nxt;
  logic [DATA_W-1:0]  sel_data_c;

  // Pin synchronisers plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      din_sync <= '0;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
      din_sync <= {din_sync[SYNC_STAGES-2:0], adc_din};
      cs_prev  <= cs_sync[SYNC_STAGES-1];
      sck_prev <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign din_s      = din_sync[SYNC_STAGES-1];
  assign cs_fall_c  = cs_prev & ~cs_s;
  assign cs_rise_c  = ~cs_prev & cs_s;
  assign sck_rise_c = ~sck_prev & sck_s;
  assign sck_fall_c = sck_prev & ~sck_s;

  // Sample word of the channel selected for the coming frame
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (cur_channel == ADDR_W'(k)) sel_data_c = chan_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      rcnt        <= '0;
      fcnt        <= '0;
      addr_sh     <= '0;
      cur_channel <= '0;
      adc_dout    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      rcnt        <= rcnt_nxt;
      fcnt        <= fcnt_nxt;
      addr_sh     <= addr_sh_nxt;
      cur_channel <= cur_channel_nxt;
      adc_dout    <= adc_dout_nxt;
      frame_done  <= frame_done_nxt;
      frame_abort <= frame_abort_nxt;
    end
  end

  // Frame sequencing; a cs_n rise takes priority over any SCK edge in the same clk
  always_comb begin
    state_nxt       = state;
    shreg_nxt       = shreg;
    rcnt_nxt        = rcnt;
    fcnt_nxt        = fcnt;
    addr_sh_nxt     = addr_sh;
    cur_channel_nxt = cur_channel;
    adc_dout_nxt    = adc_dout;
    frame_done_nxt  = 1'b0;
    frame_abort_nxt = 1'b0;

    case (state)
      IDLE: begin
        adc_dout_nxt = 1'b0;
        if (cs_fall_c) begin
          shreg_nxt   = FRAME_W'(sel_data_c);
          rcnt_nxt    = '0;
          fcnt_nxt    = '0;
          addr_sh_nxt = '0;
          state_nxt   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise_c) begin
          state_nxt       = IDLE;
          adc_dout_nxt    = 1'b0;
          frame_abort_nxt = (rcnt != '0);
        end else if (sck_rise_c) begin
          if (rcnt >= ADDR_FIRST && rcnt <= ADDR_LAST) begin
            addr_sh_nxt = {addr_sh[ADDR_W-2:0], din_s};
          end
          if (rcnt == LAST) begin
            rcnt_nxt        = '0;
            cur_channel_nxt = addr_sh;
            frame_done_nxt  = 1'b1;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end else if (sck_fall_c) begin
          // The 16th falling edge reloads so frames run back to back under a held-low cs_n
          if (fcnt == LAST) begin
            shreg_nxt    = FRAME_W'(sel_data_c);
            adc_dout_nxt = 1'b0;
            fcnt_nxt     = '0;
          end else begin
            shreg_nxt    = {shreg[FRAME_W-2:0], 1'b0};
            adc_dout_nxt = shreg[FRAME_W-2];
            fcnt_nxt     = fcnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        adc_dout_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed scenarios then randomized frames,
// checked against a channel-array model of the ADC's frame rules.
module tb_adc_spi_responder;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned N_CH   = 8;
  localparam int          HALF   = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   adc_cs_n = 1'b1;
  logic                   adc_sck = 1'b0;
  logic                   adc_din = 1'b0;
  logic                   adc_dout;
  logic [N_CH*DATA_W-1:0] chan_data = '0;
  logic [2:0]             cur_channel;
  logic                   frame_done;
  logic                   frame_abort;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [11:0] ch_m [N_CH];
  int          model_cur = 0;
  int          mod_after = -1;
  int          mod_ch = 0;
  logic [11:0] mod_val = '0;

  adc_spi_responder dut (
    .clk         (clk),
    .rst         (rst),
    .adc_cs_n    (adc_cs_n),
    .adc_sck     (adc_sck),
    .adc_din     (adc_din),
    .adc_dout    (adc_dout),
    .chan_data   (chan_data),
    .cur_channel (cur_channel),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_m[k] = v;
    chan_data[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic cs_low();
    adc_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    adc_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  // One SCK period, idle low: the master samples DOUT just before the rising edge
  task automatic sck_cycle(input logic d, output logic q);
    adc_din = d;
    wait_clk(HALF);
    q = adc_dout;
    adc_sck = 1'b1;
    wait_clk(HALF);
    adc_sck = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] addr, input int n_rise, input string tag);
    logic [15:0] exp_w, got, mask;
    logic        d, q;
    int          d0;
    exp_w = {4'b0000, ch_m[model_cur]};
    got   = '0;
    mask  = '0;
    d0    = done_cnt;
    for (int i = 0; i < n_rise; i++) begin
      if (i >= 2 && i <= 4) d = addr[4-i];
      else d = 1'($urandom);
      sck_cycle(d, q);
      got[15-i]  = q;
      mask[15-i] = 1'b1;
      if (i + 1 == mod_after) begin
        set_ch(mod_ch, mod_val);
        mod_after = -1;
      end
    end
    if (n_rise > 0) check({tag, "_dout"}, 32'(got & mask), 32'(exp_w & mask));
    wait_clk(HALF);
    if (n_rise == 16) begin
      model_cur = int'(addr);
      check({tag, "_cur"}, 32'(cur_channel), 32'(model_cur));
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    end
  endtask

  task automatic abort_frame(input logic [2:0] addr, input int k, input string tag);
    int a0, d0;
    a0 = abort_cnt;
    d0 = done_cnt;
    run_frame(addr, k, tag);
    cs_high();
    check({tag, "_abort"}, 32'(abort_cnt - a0), (k != 0) ? 32'd1 : 32'd0);
    check({tag, "_nodone"}, 32'(done_cnt - d0), 32'd0);
    check({tag, "_cur"}, 32'(cur_channel), 32'(model_cur));
    check({tag, "_dout0"}, 32'(adc_dout), 32'd0);
  endtask

  task automatic reset_mid_frame(input string tag);
    int a0, d0;
    a0 = abort_cnt;
    d0 = done_cnt;
    run_frame(3'($urandom), 7, tag);
    rst = 1'b1;
    wait_clk(2);
    check({tag, "_dout"}, 32'(adc_dout), 32'd0);
    check({tag, "_fd"}, 32'(frame_done), 32'd0);
    check({tag, "_fa"}, 32'(frame_abort), 32'd0);
    check({tag, "_cur"}, 32'(cur_channel), 32'd0);
    adc_cs_n = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(HALF);
    model_cur = 0;
    check({tag, "_cnts"}, 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
  endtask

  initial begin
    int a0, d0, mode, k;
    logic [2:0] a1, a2;

    for (int i = 0; i < int'(N_CH); i++) set_ch(i, 12'($urandom));
    wait_clk(3);
    check("rst_dout", 32'(adc_dout), 32'd0);
    check("rst_cur", 32'(cur_channel), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    rst = 1'b0;
    wait_clk(5);

    // Reset mid-frame, then a clean frame on channel 0
    cs_low();
    reset_mid_frame("t1_rst");
    set_ch(0, 12'h123);
    cs_low();
    run_frame(3'd0, 16, "t1_frame");
    cs_high();

    // Basic frame then a following frame with cs_n held low
    set_ch(0, 12'hA5C);
    set_ch(5, 12'h3F1);
    cs_low();
    run_frame(3'd5, 16, "t2_basic");
    check("t2_word", 32'(cur_channel), 32'd5);
    run_frame(3'd0, 16, "t3_follow");
    cs_high();

    // Abort after 7 rising edges while address 6 is sent
    set_ch(6, 12'h666);
    cs_low();
    abort_frame(3'd6, 7, "t4_abort");

    // Snapshot: channel 0 changes after falling edge 6
    set_ch(0, 12'hFFF);
    mod_after = 6;
    mod_ch    = 0;
    mod_val   = 12'h000;
    cs_low();
    run_frame(3'd0, 16, "t5_snap");
    cs_high();
    cs_low();
    run_frame(3'd0, 16, "t5_next");
    cs_high();

    // Continuous frames: 48 SCK cycles with cs_n low
    set_ch(0, 12'h001);
    set_ch(1, 12'h002);
    set_ch(2, 12'h003);
    a0 = abort_cnt;
    d0 = done_cnt;
    cs_low();
    run_frame(3'd1, 16, "t6_f1");
    run_frame(3'd2, 16, "t6_f2");
    run_frame(3'd3, 16, "t6_f3");
    cs_high();
    check("t6_done3", 32'(done_cnt - d0), 32'd3);
    check("t6_noabort", 32'(abort_cnt - a0), 32'd0);

    // cs_n rise coincident with the 16th rising edge: the edge is dropped
    a0 = abort_cnt;
    d0 = done_cnt;
    cs_low();
    run_frame(3'd7, 15, "tc_coinc");
    adc_sck  = 1'b1;
    adc_cs_n = 1'b1;
    wait_clk(HALF);
    adc_sck = 1'b0;
    wait_clk(HALF);
    check("tc_abort", 32'(abort_cnt - a0), 32'd1);
    check("tc_nodone", 32'(done_cnt - d0), 32'd0);
    check("tc_cur", 32'(cur_channel), 32'(model_cur));

    // Empty frame: cs_n low then high with no SCK
    cs_low();
    abort_frame(3'd0, 0, "te_empty");

    // Randomized frames, back-to-back pairs and aborts
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < int'(N_CH); i++) set_ch(i, 12'($urandom));
      mode = int'($urandom_range(0, 3));
      a1 = 3'($urandom);
      a2 = 3'($urandom);
      if (mode <= 1) begin
        cs_low();
        run_frame(a1, 16, "rnd_full");
        cs_high();
      end else if (mode == 2) begin
        a0 = abort_cnt;
        cs_low();
        run_frame(a1, 16, "rnd_pair1");
        run_frame(a2, 16, "rnd_pair2");
        cs_high();
        check("rnd_pair_noabort", 32'(abort_cnt - a0), 32'd0);
      end else begin
        k = int'($urandom_range(0, 15));
        cs_low();
        abort_frame(a1, k, "rnd_abort");
      end
    end

    // Reset with a nonzero channel selected clears it back to channel 0
    cs_low();
    run_frame(3'd5, 16, "tr_pre");
    cs_high();
    cs_low();
    reset_mid_frame("tr_rst");
    cs_low();
    run_frame(3'd2, 16, "tr_post");
    cs_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
